// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath constants and types for the pipeline registers
// (ID_EX, EX_MEM, MEM_WB) and the writeback / register-file stage.
//   DATA_W   - register / datapath width
//   ADDR_W   - register index width
//   NUM_REGS - architectural register count (entry 0 hardwired to zero)
//   REG_ZERO - index of the hardwired-zero register
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

    // Writeback commit request as seen by the forwarding unit and read ports.
    typedef struct packed {
        logic     we;
        reg_idx_t wn;
        word_t    data;
    } wb_req_t;

endpackage : cpu_pkg

// File: rtl/wb_regfile_read_port.sv
// rf_read_port: one combinational register-file read port with r0 forced to
// zero and same-cycle bypass of the writeback value.
//   addr  in  register index to read
//   regs  in  view of stored entries r1..r(NUM_REGS-1); element k holds r(k+1)
//   wb    in  current writeback request (enable, target, value)
//   data  out read data
module rf_read_port
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
    input  logic [ADDR_W-1:0]                  addr,
    input  logic [NUM_REGS-2:0][DATA_W-1:0]    regs,
    input  logic                               wb_we,
    input  logic [ADDR_W-1:0]                  wb_wn,
    input  logic [DATA_W-1:0]                  wb_data,
    output logic [DATA_W-1:0]                  data
);

    logic [ADDR_W-1:0] idx;

    // r0 is not stored, so entry k of the array holds register k+1.
    assign idx = addr - ADDR_W'(1);

    always_comb begin
        data = '0;
        if (addr == ADDR_W'(REG_ZERO)) begin
            data = '0;
        end else if (wb_we && (wb_wn == addr)) begin
            // Bypass: the write committing at this edge is already visible to ID.
            data = wb_data;
        end else begin
            data = regs[idx];
        end
    end

endmodule : rf_read_port

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage. Selects load data vs ALU result, commits it to
// the architectural register file, serves two ID read ports with bypass, and
// exports the writeback value/target plus a running commit count.
//   clk, reset     clock; synchronous active-high reset (reset wins over writes)
//   RegWrite_in    writeback enable from MEM/WB
//   MemtoReg_in    1: write dmem_rdata_in, 0: write alu_out_in
//   dmem_rdata_in  load data
//   alu_out_in     ALU result
//   rfile_wn_in    destination register index
//   rs_addr/rs_data, rt_addr/rt_data   combinational read ports
//   wb_data, wb_wn, wb_we              writeback value/target/effective enable
//   wb_count       committed writes since reset (registered, wraps)
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic [DATA_W-1:0] dmem_rdata_in,
    input  logic [DATA_W-1:0] alu_out_in,
    input  logic [ADDR_W-1:0] rfile_wn_in,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_wn,
    output logic              wb_we,
    output logic [31:0]       wb_count
);

    localparam int NUM_PORTS = 2;

    // r1..r(NUM_REGS-1); r0 reads as zero and is never stored.
    logic [NUM_REGS-2:0][DATA_W-1:0] regs;
    logic [31:0]                     cnt_q;
    logic [ADDR_W-1:0]               wr_idx;

    logic [NUM_PORTS-1:0][ADDR_W-1:0] port_addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] port_data;

    assign wb_data = MemtoReg_in ? dmem_rdata_in : alu_out_in;
    assign wb_wn   = rfile_wn_in;
    // Gating with reset keeps the bypass and the commit consistent: a write
    // dropped by reset is also not forwarded.
    assign wb_we   = RegWrite_in && (rfile_wn_in != ADDR_W'(REG_ZERO)) && !reset;
    assign wr_idx  = rfile_wn_in - ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            regs  <= '0;
            cnt_q <= '0;
        end else if (wb_we) begin
            regs[wr_idx] <= wb_data;
            cnt_q        <= cnt_q + 32'd1;
        end
    end

    assign wb_count = cnt_q;

    assign port_addr[0] = rs_addr;
    assign port_addr[1] = rt_addr;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_REGS (NUM_REGS)
        ) u_port (
            .addr    (port_addr[p]),
            .regs    (regs),
            .wb_we   (wb_we),
            .wb_wn   (wb_wn),
            .wb_data (wb_data),
            .data    (port_data[p])
        );
    end

    assign rs_data = port_data[0];
    assign rt_data = port_data[1];

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_in;
    logic        MemtoReg_in;
    logic [31:0] dmem_rdata_in;
    logic [31:0] alu_out_in;
    logic [4:0]  rfile_wn_in;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data;
    logic [4:0]  wb_wn;
    logic        wb_we;
    logic [31:0] wb_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite_in   (RegWrite_in),
        .MemtoReg_in   (MemtoReg_in),
        .dmem_rdata_in (dmem_rdata_in),
        .alu_out_in    (alu_out_in),
        .rfile_wn_in   (rfile_wn_in),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .wb_data       (wb_data),
        .wb_wn         (wb_wn),
        .wb_we         (wb_we),
        .wb_count      (wb_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWrite_in   = 1'b0;
        MemtoReg_in   = 1'b0;
        dmem_rdata_in = '0;
        alu_out_in    = '0;
        rfile_wn_in   = '0;
    endtask

    task automatic test_reset();
        idle();
        reset       = 1'b1;
        RegWrite_in = 1'b1;
        rfile_wn_in = 5'd4;
        alu_out_in  = 32'h0BAD_0BAD;
        #1;
        n_cmp++;
        if (wb_we !== 1'b0) begin
            n_bad++; $display("FAIL reset_we: got %b want 0", wb_we);
        end
        tick();
        idle();
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a);
            rt_addr = 5'(31 - a);
            #1;
            n_cmp++;
            if (rs_data !== 32'd0) begin
                n_bad++; $display("FAIL reset_rs[%0d]: got %h want 0", a, rs_data);
            end
            n_cmp++;
            if (rt_data !== 32'd0) begin
                n_bad++; $display("FAIL reset_rt[%0d]: got %h want 0", 31 - a, rt_data);
            end
        end
        n_cmp++;
        if (wb_count !== 32'd0) begin
            n_bad++; $display("FAIL reset_count: got %h want 0", wb_count);
        end
    endtask

    task automatic test_alu_write();
        RegWrite_in   = 1'b1;
        MemtoReg_in   = 1'b0;
        alu_out_in    = 32'h1234_5678;
        dmem_rdata_in = 32'hCAFE_0000;
        rfile_wn_in   = 5'd5;
        #1;
        n_cmp++;
        if (wb_data !== 32'h1234_5678) begin
            n_bad++; $display("FAIL alu_wbdata: got %h want 12345678", wb_data);
        end
        n_cmp++;
        if (wb_we !== 1'b1 || wb_wn !== 5'd5) begin
            n_bad++; $display("FAIL alu_we_wn: got %b/%0d want 1/5", wb_we, wb_wn);
        end
        tick();
        idle();
        rs_addr = 5'd5;
        #1;
        n_cmp++;
        if (rs_data !== 32'h1234_5678) begin
            n_bad++; $display("FAIL alu_read: got %h want 12345678", rs_data);
        end
        n_cmp++;
        if (wb_count !== 32'd1) begin
            n_bad++; $display("FAIL alu_count: got %0d want 1", wb_count);
        end
    endtask

    task automatic test_load_bypass();
        RegWrite_in   = 1'b1;
        MemtoReg_in   = 1'b1;
        dmem_rdata_in = 32'hDEAD_BEEF;
        alu_out_in    = 32'h0000_0001;
        rfile_wn_in   = 5'd9;
        rs_addr       = 5'd9;
        rt_addr       = 5'd9;
        #1;
        n_cmp++;
        if (rs_data !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL bypass_rs: got %h want deadbeef", rs_data);
        end
        n_cmp++;
        if (rt_data !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL bypass_rt: got %h want deadbeef", rt_data);
        end
        rt_addr = 5'd5;
        #1;
        n_cmp++;
        if (rt_data !== 32'h1234_5678) begin
            n_bad++; $display("FAIL nobypass_rt: got %h want 12345678", rt_data);
        end
        rt_addr = 5'd9;
        tick();
        idle();
        #1;
        n_cmp++;
        if (rs_data !== 32'hDEAD_BEEF || rt_data !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL load_stored: got %h/%h want deadbeef", rs_data, rt_data);
        end
        n_cmp++;
        if (wb_count !== 32'd2) begin
            n_bad++; $display("FAIL load_count: got %0d want 2", wb_count);
        end
    endtask

    task automatic test_r0_write();
        RegWrite_in = 1'b1;
        MemtoReg_in = 1'b0;
        alu_out_in  = 32'hFFFF_FFFF;
        rfile_wn_in = 5'd0;
        rs_addr     = 5'd0;
        rt_addr     = 5'd31;
        #1;
        n_cmp++;
        if (rs_data !== 32'd0) begin
            n_bad++; $display("FAIL r0_read: got %h want 0", rs_data);
        end
        n_cmp++;
        if (wb_we !== 1'b0) begin
            n_bad++; $display("FAIL r0_we: got %b want 0", wb_we);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (wb_count !== 32'd2) begin
            n_bad++; $display("FAIL r0_count: got %0d want 2", wb_count);
        end
        n_cmp++;
        if (rt_data !== 32'd0) begin
            n_bad++; $display("FAIL r31_untouched: got %h want 0", rt_data);
        end
    endtask

    task automatic test_back_to_back();
        RegWrite_in = 1'b1;
        rfile_wn_in = 5'd1; alu_out_in = 32'h0000_0011; tick();
        rfile_wn_in = 5'd2; alu_out_in = 32'h0000_0022; tick();
        rfile_wn_in = 5'd1; alu_out_in = 32'h0000_0033; tick();
        // Stored r1 is 0x33; a pending write of 0x44 must win on the bypass.
        rfile_wn_in = 5'd1; alu_out_in = 32'h0000_0044;
        rs_addr = 5'd1;
        rt_addr = 5'd2;
        #1;
        n_cmp++;
        if (rs_data !== 32'h44) begin
            n_bad++; $display("FAIL b2b_bypass: got %h want 44", rs_data);
        end
        n_cmp++;
        if (rt_data !== 32'h22) begin
            n_bad++; $display("FAIL b2b_r2: got %h want 22", rt_data);
        end
        RegWrite_in = 1'b0;
        #1;
        n_cmp++;
        if (rs_data !== 32'h33) begin
            n_bad++; $display("FAIL b2b_r1: got %h want 33", rs_data);
        end
        n_cmp++;
        if (wb_count !== 32'd5) begin
            n_bad++; $display("FAIL b2b_count: got %0d want 5", wb_count);
        end
        idle();
    endtask

    task automatic test_reset_priority();
        reset       = 1'b1;
        RegWrite_in = 1'b1;
        MemtoReg_in = 1'b0;
        alu_out_in  = 32'h0000_00AA;
        rfile_wn_in = 5'd3;
        rs_addr     = 5'd3;
        #1;
        n_cmp++;
        if (wb_we !== 1'b0 || rs_data !== 32'd0) begin
            n_bad++; $display("FAIL rstpri_comb: got we=%b rs=%h want 0/0", wb_we, rs_data);
        end
        tick();
        reset = 1'b0;
        idle();
        rt_addr = 5'd5;
        #1;
        n_cmp++;
        if (rs_data !== 32'd0) begin
            n_bad++; $display("FAIL rstpri_r3: got %h want 0", rs_data);
        end
        n_cmp++;
        if (rt_data !== 32'd0) begin
            n_bad++; $display("FAIL rstpri_r5: got %h want 0", rt_data);
        end
        n_cmp++;
        if (wb_count !== 32'd0) begin
            n_bad++; $display("FAIL rstpri_count: got %0d want 0", wb_count);
        end
        rfile_wn_in = 5'd3;
        alu_out_in  = 32'h0000_0055;
        tick();
        MemtoReg_in   = 1'bx;
        alu_out_in    = 'x;
        dmem_rdata_in = 'x;
        rfile_wn_in   = 'x;
        tick();
        idle();
        #1;
        n_cmp++;
        if (rs_data !== 32'd0 || wb_count !== 32'd0) begin
            n_bad++; $display("FAIL nowrite_r3: got %h cnt %0d want 0/0", rs_data, wb_count);
        end
    endtask

    task automatic test_count_wrap();
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        #1;
        n_cmp++;
        if (wb_count !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL wrap_preload: got %h want ffffffff", wb_count);
        end
        RegWrite_in = 1'b1;
        alu_out_in  = 32'h0000_0077;
        rfile_wn_in = 5'd7;
        tick();
        idle();
        rs_addr = 5'd7;
        #1;
        n_cmp++;
        if (wb_count !== 32'd0) begin
            n_bad++; $display("FAIL wrap_count: got %h want 0", wb_count);
        end
        n_cmp++;
        if (rs_data !== 32'h77) begin
            n_bad++; $display("FAIL wrap_r7: got %h want 77", rs_data);
        end
    endtask

    initial begin
        reset   = 1'b1;
        rs_addr = '0;
        rt_addr = '0;
        idle();
        #2;
        test_reset();
        test_alu_write();
        test_load_bypass();
        test_r0_write();
        test_back_to_back();
        test_reset_priority();
        test_count_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_wb_regfile
